// File: rtl/ioctl_upload_server_if.sv
// ---------------------------------------------------------------------------
// ioctl_upload_server_if
//
// Purpose: bundles every signal between the upload server, hps_io's upload
// interface, the shared synchronous memory read port and the save/status
// sideband. Only clk and reset stay outside the bundle.
//
// Signal summary (direction as seen by the server, i.e. the slave modport):
//   save_trig         in   one-cycle pulse that starts a core-initiated save
//   ioctl_upload_req  out  asks the HPS to begin an upload
//   ioctl_upload      in   HPS upload in progress
//   ioctl_index       in   transfer index from hps_io
//   ioctl_rd          in   one-cycle byte read strobe
//   ioctl_addr        in   byte address of the read (25 bits)
//   ioctl_din         out  byte returned to the HPS
//   ioctl_wait        out  stalls the HPS while a byte is being fetched
//   mem_busy          in   core owns the memory port this cycle
//   mem_rd            out  one-cycle memory read strobe
//   mem_addr          out  memory read address (ADDR_W bits)
//   mem_q             in   memory read data
//   busy              out  server is not idle
//   done              out  one-cycle pulse at the end of an upload
//   byte_cnt          out  bytes served in the current or last upload
//
// Modports: slave = the upload server, master = the surrounding system
// (hps_io, memory, core) or a testbench standing in for it.
// ---------------------------------------------------------------------------
interface ioctl_upload_server_if #(
    parameter int ADDR_W = 12
);
    logic              save_trig;
    logic              ioctl_upload_req;
    logic              ioctl_upload;
    logic [7:0]        ioctl_index;
    logic              ioctl_rd;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_din;
    logic              ioctl_wait;
    logic              mem_busy;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_q;
    logic              busy;
    logic              done;
    logic [15:0]       byte_cnt;

    modport slave (
        input  save_trig, ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
               mem_busy, mem_q,
        output ioctl_upload_req, ioctl_din, ioctl_wait, mem_rd, mem_addr,
               busy, done, byte_cnt
    );

    modport master (
        output save_trig, ioctl_upload, ioctl_index, ioctl_rd, ioctl_addr,
               mem_busy, mem_q,
        input  ioctl_upload_req, ioctl_din, ioctl_wait, mem_rd, mem_addr,
               busy, done, byte_cnt
    );
endinterface

// File: rtl/ioctl_upload_server.sv
// ---------------------------------------------------------------------------
// ioctl_upload_server
//
// Purpose: serves HPS upload (core -> HPS) transfers out of an on-chip memory
// such as console RAM or cartridge save data. It is the reader counterpart of
// the ioctl download path. A save is started either by the core (save_trig,
// which raises ioctl_upload_req towards the HPS) or by the host opening an
// upload on our index. Each ioctl_rd is answered with one byte: addresses
// beyond SIZE return PAD at once, valid addresses are fetched through a
// synchronous read port shared with the core, stalling the HPS with
// ioctl_wait until the byte is in ioctl_din.
//
// Ports:
//   clk    in  system clock
//   reset  in  synchronous active-high reset
//   bus    ioctl_upload_server_if.slave (HPS upload, memory port, status)
//
// Parameters:
//   ADDR_W       memory address width
//   SIZE         number of valid bytes; higher addresses return PAD
//   PAD          byte returned for out-of-range addresses
//   MEM_LAT      cycles from mem_rd to valid mem_q (1..3)
//   INDEX        ioctl_index value this block answers to
//   REQ_TIMEOUT  cycles ioctl_upload_req is held before giving up
// ---------------------------------------------------------------------------
module ioctl_upload_server #(
    parameter int          ADDR_W      = 12,
    parameter int          SIZE        = 2048,
    parameter logic [7:0]  PAD         = 8'hFF,
    parameter int          MEM_LAT     = 1,
    parameter logic [7:0]  INDEX       = 8'd1,
    parameter logic [15:0] REQ_TIMEOUT = 16'hFFFF
) (
    input logic                  clk,
    input logic                  reset,
    ioctl_upload_server_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACTIVE,
        S_ARB,
        S_LAT
    } state_e;

    localparam logic [24:0] SIZE_A     = 25'(SIZE);
    localparam logic [24:0] ADDR_LIMIT = 25'(1) << ADDR_W;
    localparam logic [1:0]  LAT_LAST   = 2'(MEM_LAT);
    localparam logic [15:0] TMO_LAST   = REQ_TIMEOUT - 16'd1;

    state_e            state_q,    state_d;
    logic              req_q,      req_d;
    logic [7:0]        din_q,      din_d;
    logic              wait_q,     wait_d;
    logic              mem_rd_q,   mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              done_q,     done_d;
    logic [15:0]       byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0] addr_lat_q, addr_lat_d;
    logic [15:0]       tmo_q,      tmo_d;
    logic [1:0]        lat_cnt_q,  lat_cnt_d;
    logic              abort_q,    abort_d;
    logic              sel_prev_q, sel_prev_d;

    logic        sel;
    logic        sel_rise;
    logic        rd_accept;
    logic        in_range;
    logic        abort_now;
    logic [15:0] byte_cnt_inc;

    // The upload is ours only while the host runs it on our index.
    assign sel       = bus.ioctl_upload && (bus.ioctl_index == INDEX);
    assign sel_rise  = sel && !sel_prev_q;
    // A read strobe while stalled is a host protocol violation: drop it.
    assign rd_accept = bus.ioctl_rd && sel && !wait_q;
    // Both checks are kept so SIZE larger than the address space stays safe.
    assign in_range  = (bus.ioctl_addr < SIZE_A) && (bus.ioctl_addr < ADDR_LIMIT);
    // Once the host has left, the in-flight fetch still completes but its
    // data is thrown away.
    assign abort_now = abort_q || !sel;
    assign byte_cnt_inc = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;

    always_comb begin
        // NOTE: every _d starts from its held value so no path through the
        // case below can leave a signal unassigned and infer a latch.
        state_d    = state_q;
        req_d      = req_q;
        din_d      = din_q;
        wait_d     = wait_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        done_d     = 1'b0;
        byte_cnt_d = byte_cnt_q;
        addr_lat_d = addr_lat_q;
        tmo_d      = tmo_q;
        lat_cnt_d  = lat_cnt_q;
        abort_d    = abort_q;
        sel_prev_d = sel;

        case (state_q)
            S_IDLE: begin
                req_d  = 1'b0;
                wait_d = 1'b0;
                // A host-opened upload wins over a same-cycle trigger: the
                // host is already there, so there is nothing to request.
                if (sel_rise) begin
                    state_d    = S_ACTIVE;
                    byte_cnt_d = '0;
                end else if (bus.save_trig) begin
                    state_d    = S_REQ;
                    req_d      = 1'b1;
                    tmo_d      = '0;
                    byte_cnt_d = '0;
                end
            end

            S_REQ: begin
                if (sel) begin
                    state_d = S_ACTIVE;
                    req_d   = 1'b0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            S_ACTIVE: begin
                // An out-of-range answer stalls for exactly one cycle.
                wait_d = 1'b0;
                if (!sel) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else if (rd_accept) begin
                    wait_d = 1'b1;
                    if (in_range) begin
                        state_d    = S_ARB;
                        addr_lat_d = bus.ioctl_addr[ADDR_W-1:0];
                        abort_d    = 1'b0;
                    end else begin
                        din_d      = PAD;
                        byte_cnt_d = byte_cnt_inc;
                    end
                end
            end

            S_ARB: begin
                abort_d = abort_now;
                if (!bus.mem_busy) begin
                    state_d    = S_LAT;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = addr_lat_q;
                    lat_cnt_d  = '0;
                end
            end

            S_LAT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    wait_d = 1'b0;
                    if (abort_now) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d    = S_ACTIVE;
                        din_d      = bus.mem_q;
                        byte_cnt_d = byte_cnt_inc;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                    abort_d   = abort_now;
                end
            end

            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                wait_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            req_q      <= 1'b0;
            din_q      <= 8'h00;
            wait_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            done_q     <= 1'b0;
            byte_cnt_q <= '0;
            addr_lat_q <= '0;
            tmo_q      <= '0;
            lat_cnt_q  <= '0;
            abort_q    <= 1'b0;
            sel_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, whatever order the lines are written in.
            state_q    <= state_d;
            req_q      <= req_d;
            din_q      <= din_d;
            wait_q     <= wait_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            done_q     <= done_d;
            byte_cnt_q <= byte_cnt_d;
            addr_lat_q <= addr_lat_d;
            tmo_q      <= tmo_d;
            lat_cnt_q  <= lat_cnt_d;
            abort_q    <= abort_d;
            sel_prev_q <= sel_prev_d;
        end
    end

    assign bus.ioctl_upload_req = req_q;
    assign bus.ioctl_din        = din_q;
    assign bus.ioctl_wait       = wait_q;
    assign bus.mem_rd           = mem_rd_q;
    assign bus.mem_addr         = mem_addr_q;
    assign bus.done             = done_q;
    assign bus.byte_cnt         = byte_cnt_q;
    assign bus.busy             = (state_q != S_IDLE);

endmodule

// File: tb/tb_ioctl_upload_server.sv
// ---------------------------------------------------------------------------
// tb_ioctl_upload_server
//
// Drives ioctl_upload_server through the HPS side and a behavioural memory
// with a one-cycle synchronous read. Expected bytes come from the bench's own
// memory image (addr < SIZE ? mem[addr] : PAD); expected timings come from
// the documented latencies (out of range: one stall cycle; in range: the
// first non-busy arbitration cycle plus 1 + MEM_LAT).
// ---------------------------------------------------------------------------
module tb_ioctl_upload_server;

    localparam int          ADDR_W      = 12;
    localparam int          SIZE        = 2048;
    localparam logic [7:0]  PAD         = 8'hFF;
    localparam int          MEM_LAT     = 1;
    localparam logic [7:0]  INDEX       = 8'd1;
    localparam logic [15:0] REQ_TIMEOUT = 16'd16;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ioctl_upload_server_if #(.ADDR_W(ADDR_W)) bus();

    ioctl_upload_server #(
        .ADDR_W     (ADDR_W),
        .SIZE       (SIZE),
        .PAD        (PAD),
        .MEM_LAT    (MEM_LAT),
        .INDEX      (INDEX),
        .REQ_TIMEOUT(REQ_TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Memory image and one-cycle synchronous read port. Garbage on mem_q
    // when no read was issued exposes captures taken at the wrong cycle.
    logic [7:0] mem [SIZE];

    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_q <= mem[int'(bus.mem_addr) % SIZE];
        else            bus.mem_q <= 8'($urandom);
    end

    int         vectors    = 0;
    int         miscompares = 0;
    logic [7:0] model_din  = 8'h00;

    function automatic logic [7:0] exp_byte(input logic [24:0] a);
        return (a < 25'(SIZE)) ? mem[int'(a)] : PAD;
    endfunction

    function automatic int exp_rd_cycle(input int busy_hold);
        return (busy_hold > 1) ? busy_hold : 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session();
        bus.ioctl_index  = INDEX;
        bus.ioctl_upload = 1'b1;
        tick();
    endtask

    task automatic end_session(output bit seen, output int cyc);
        bus.ioctl_upload = 1'b0;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 8) begin
            tick();
            cyc++;
            if (bus.done) seen = 1'b1;
        end
    endtask

    // One host read. busy_hold = number of cycles mem_busy stays high,
    // counting the cycle of the strobe. lat = edges after the strobe edge
    // until ioctl_wait is low; rd_cyc = same count at which mem_rd was seen.
    task automatic host_read(input logic [24:0] a, input int busy_hold,
                             input bit violate, output logic [7:0] d,
                             output bit w0, output int lat, output int nrd,
                             output int rd_cyc, output bit clash,
                             output logic [ADDR_W-1:0] rd_addr);
        bit busy_drv;
        nrd = 0; rd_cyc = -1; clash = 1'b0; rd_addr = '0;
        bus.ioctl_addr = a;
        bus.ioctl_rd   = 1'b1;
        busy_drv       = (busy_hold > 0);
        bus.mem_busy   = busy_drv;
        tick();
        bus.ioctl_rd = 1'b0;
        lat = 0;
        w0  = bus.ioctl_wait;
        if (bus.mem_rd) begin nrd++; rd_cyc = 0; clash = busy_drv; end
        while (bus.ioctl_wait && lat < 200) begin
            busy_drv     = (lat + 1 < busy_hold);
            bus.mem_busy = busy_drv;
            if (violate) begin
                bus.ioctl_rd   = 1'b1;
                bus.ioctl_addr = 25'($urandom_range(0, SIZE - 1));
            end
            tick();
            lat++;
            bus.ioctl_rd = 1'b0;
            if (bus.mem_rd) begin
                nrd++; rd_cyc = lat; rd_addr = bus.mem_addr;
                if (busy_drv) clash = 1'b1;
            end
        end
        bus.mem_busy = 1'b0;
        d = bus.ioctl_din;
    endtask

    task automatic test_reset();
        logic [40:0] snap;
        reset = 1'b1;
        repeat (3) tick();
        snap = {bus.ioctl_upload_req, bus.ioctl_din, bus.ioctl_wait, bus.mem_rd,
                bus.mem_addr, bus.busy, bus.done, bus.byte_cnt};
        vectors++;
        if (snap !== 41'd0) begin
            miscompares++; $display("FAIL reset_state: got %h expected 0", snap);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (bus.busy !== 1'b0) begin
            miscompares++; $display("FAIL reset_idle: busy got %b expected 0", bus.busy);
        end
    endtask

    task automatic test_happy_path();
        logic [7:0] d; bit w0, clash, seen; int lat, nrd, rc, cyc;
        logic [ADDR_W-1:0] ra;
        mem[0] = 8'h12; mem[1] = 8'h34;
        bus.save_trig = 1'b1; tick(); bus.save_trig = 1'b0;
        vectors++;
        if ({bus.ioctl_upload_req, bus.busy} !== 2'b11) begin
            miscompares++; $display("FAIL happy_req: req,busy got %b expected 11", {bus.ioctl_upload_req, bus.busy});
        end
        start_session();
        vectors++;
        if ({bus.ioctl_upload_req, bus.busy} !== 2'b01) begin
            miscompares++; $display("FAIL happy_req_drop: req,busy got %b expected 01", {bus.ioctl_upload_req, bus.busy});
        end
        for (int i = 0; i < 2; i++) begin
            host_read(25'(i), 0, 1'b0, d, w0, lat, nrd, rc, clash, ra);
            vectors++;
            if (d !== exp_byte(25'(i))) begin
                miscompares++; $display("FAIL happy_data[%0d]: got %h expected %h", i, d, exp_byte(25'(i)));
            end
            vectors++;
            if ({w0, 32'(lat), 32'(nrd), ra} !== {1'b1, 32'(2 + MEM_LAT), 32'd1, ADDR_W'(i)}) begin
                miscompares++; $display("FAIL happy_timing[%0d]: wait0=%b lat=%0d nrd=%0d addr=%h expected 1 %0d 1 %h", i, w0, lat, nrd, ra, 2 + MEM_LAT, i);
            end
            model_din = exp_byte(25'(i));
        end
        end_session(seen, cyc);
        vectors++;
        if (!seen || cyc !== 1) begin
            miscompares++; $display("FAIL happy_done: seen=%b after %0d expected 1 after 1", seen, cyc);
        end
        tick();
        vectors++;
        if ({bus.done, bus.busy, bus.byte_cnt} !== {2'b00, 16'd2}) begin
            miscompares++; $display("FAIL happy_end: done=%b busy=%b cnt=%0d expected 0 0 2", bus.done, bus.busy, bus.byte_cnt);
        end
    endtask

    task automatic test_arbitration();
        logic [7:0] d; bit w0, clash, seen; int lat, nrd, rc, cyc;
        logic [ADDR_W-1:0] ra;
        mem[5] = 8'hA5;
        start_session();
        vectors++;
        if ({bus.busy, bus.byte_cnt} !== {1'b1, 16'd0}) begin
            miscompares++; $display("FAIL arb_start: busy=%b cnt=%0d expected 1 0", bus.busy, bus.byte_cnt);
        end
        host_read(25'd5, 10, 1'b0, d, w0, lat, nrd, rc, clash, ra);
        vectors++;
        if (d !== 8'hA5) begin
            miscompares++; $display("FAIL arb_data: got %h expected a5", d);
        end
        vectors++;
        if ({clash, 32'(nrd), 32'(rc), 32'(lat)} !== {1'b0, 32'd1, 32'd10, 32'(10 + 1 + MEM_LAT)}) begin
            miscompares++; $display("FAIL arb_timing: clash=%b nrd=%0d rd_at=%0d lat=%0d expected 0 1 10 %0d", clash, nrd, rc, lat, 11 + MEM_LAT);
        end
        model_din = 8'hA5;
        end_session(seen, cyc);
        vectors++;
        if (!seen) begin
            miscompares++; $display("FAIL arb_done: seen=%b expected 1", seen);
        end
    endtask

    task automatic test_out_of_range();
        logic [24:0] addrs [3] = '{25'd2048, 25'd4095, 25'h1000000};
        logic [7:0] d; bit w0, clash, seen; int lat, nrd, rc, cyc;
        logic [ADDR_W-1:0] ra;
        start_session();
        foreach (addrs[i]) begin
            host_read(addrs[i], 0, 1'b0, d, w0, lat, nrd, rc, clash, ra);
            vectors++;
            if ({d, w0, 32'(lat), 32'(nrd)} !== {PAD, 1'b1, 32'd1, 32'd0}) begin
                miscompares++; $display("FAIL oor[%h]: din=%h wait0=%b lat=%0d nrd=%0d expected ff 1 1 0", addrs[i], d, w0, lat, nrd);
            end
            model_din = PAD;
        end
        end_session(seen, cyc);
        vectors++;
        if ({seen, bus.byte_cnt} !== {1'b1, 16'd3}) begin
            miscompares++; $display("FAIL oor_count: done=%b cnt=%0d expected 1 3", seen, bus.byte_cnt);
        end
    endtask

    task automatic test_timeout();
        int  n = 0;
        bit  done_seen = 1'b0;
        bus.save_trig = 1'b1; tick(); bus.save_trig = 1'b0;
        while (bus.ioctl_upload_req && n < 100) begin
            n++;
            if (bus.done) done_seen = 1'b1;
            tick();
        end
        if (bus.done) done_seen = 1'b1;
        vectors++;
        if (n !== int'(REQ_TIMEOUT)) begin
            miscompares++; $display("FAIL timeout_len: req high %0d cycles expected %0d", n, REQ_TIMEOUT);
        end
        tick();
        if (bus.done) done_seen = 1'b1;
        vectors++;
        if ({done_seen, bus.busy, bus.byte_cnt} !== {2'b00, 16'd0}) begin
            miscompares++; $display("FAIL timeout_end: done=%b busy=%b cnt=%0d expected 0 0 0", done_seen, bus.busy, bus.byte_cnt);
        end
    endtask

    task automatic test_index_filter();
        bit stir = 1'b0;
        bus.ioctl_index  = 8'd2;
        bus.ioctl_upload = 1'b1;
        for (int i = 0; i < 24; i++) begin
            bus.ioctl_rd   = (i % 3 == 0);
            bus.ioctl_addr = 25'($urandom_range(0, SIZE - 1));
            tick();
            if (bus.ioctl_wait || bus.mem_rd || bus.busy || bus.done) stir = 1'b1;
        end
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_upload = 1'b0;
        tick();
        vectors++;
        if ({stir, bus.ioctl_din} !== {1'b0, model_din}) begin
            miscompares++; $display("FAIL index_filter: activity=%b din=%h expected 0 %h", stir, bus.ioctl_din, model_din);
        end
    endtask

    task automatic test_abort();
        int nrd = 0, rd_at = -1, done_at = -1, cyc = 0;
        mem[7] = 8'h5C;
        start_session();
        bus.ioctl_addr = 25'd7; bus.ioctl_rd = 1'b1; bus.mem_busy = 1'b1;
        tick();
        bus.ioctl_rd = 1'b0;
        repeat (2) begin tick(); if (bus.mem_rd) nrd++; end
        bus.ioctl_upload = 1'b0;
        repeat (3) begin tick(); if (bus.mem_rd) nrd++; end
        vectors++;
        if ({32'(nrd), bus.ioctl_wait} !== {32'd0, 1'b1}) begin
            miscompares++; $display("FAIL abort_hold: nrd=%0d wait=%b expected 0 1", nrd, bus.ioctl_wait);
        end
        bus.mem_busy = 1'b0;
        while (done_at < 0 && cyc < 20) begin
            tick();
            cyc++;
            if (bus.mem_rd) begin nrd++; rd_at = cyc; end
            if (bus.done) done_at = cyc;
        end
        vectors++;
        if ({32'(nrd), 32'(rd_at), 32'(done_at)} !== {32'd1, 32'd1, 32'(2 + MEM_LAT)}) begin
            miscompares++; $display("FAIL abort_seq: nrd=%0d rd_at=%0d done_at=%0d expected 1 1 %0d", nrd, rd_at, done_at, 2 + MEM_LAT);
        end
        tick();
        vectors++;
        if ({bus.busy, bus.done, bus.ioctl_wait, bus.ioctl_din, bus.byte_cnt} !== {3'b000, model_din, 16'd0}) begin
            miscompares++; $display("FAIL abort_end: busy=%b done=%b wait=%b din=%h cnt=%0d expected 0 0 0 %h 0", bus.busy, bus.done, bus.ioctl_wait, bus.ioctl_din, bus.byte_cnt, model_din);
        end
    endtask

    task automatic test_reset_mid_lat();
        logic [7:0] d; bit w0, clash; int lat, nrd, rc;
        logic [ADDR_W-1:0] ra;
        logic [40:0] snap;
        mem[9] = 8'hC3;
        start_session();
        host_read(25'd9, 0, 1'b0, d, w0, lat, nrd, rc, clash, ra);
        bus.ioctl_addr = 25'd9; bus.ioctl_rd = 1'b1;
        tick();
        bus.ioctl_rd = 1'b0;
        tick();
        vectors++;
        if (bus.mem_rd !== 1'b1) begin
            miscompares++; $display("FAIL rst_lat_setup: mem_rd got %b expected 1", bus.mem_rd);
        end
        reset = 1'b1;
        tick();
        snap = {bus.ioctl_upload_req, bus.ioctl_din, bus.ioctl_wait, bus.mem_rd,
                bus.mem_addr, bus.busy, bus.done, bus.byte_cnt};
        vectors++;
        if (snap !== 41'd0) begin
            miscompares++; $display("FAIL rst_lat_state: got %h expected 0", snap);
        end
        bus.ioctl_upload = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            miscompares++; $display("FAIL rst_lat_after: done=%b busy=%b expected 0 0", bus.done, bus.busy);
        end
        model_din = 8'h00;
    endtask

    task automatic test_host_initiated();
        logic [7:0] d; bit w0, clash, seen; int lat, nrd, rc, cyc;
        logic [ADDR_W-1:0] ra;
        for (int i = 0; i < 300; i++) mem[i] = 8'(i);
        start_session();
        for (int i = 0; i < 300; i++) begin
            host_read(25'(i), 0, 1'b0, d, w0, lat, nrd, rc, clash, ra);
            vectors++;
            if ({d, 32'(lat)} !== {8'(i), 32'(2 + MEM_LAT)}) begin
                miscompares++; $display("FAIL host_byte[%0d]: din=%h lat=%0d expected %h %0d", i, d, lat, 8'(i), 2 + MEM_LAT);
            end
            if (i == 100) begin
                bus.save_trig = 1'b1; tick(); bus.save_trig = 1'b0;
                vectors++;
                if (bus.ioctl_upload_req !== 1'b0) begin
                    miscompares++; $display("FAIL host_trig_ignored: req got %b expected 0", bus.ioctl_upload_req);
                end
            end
        end
        model_din = 8'(299);
        end_session(seen, cyc);
        vectors++;
        if ({seen, bus.byte_cnt} !== {1'b1, 16'd300}) begin
            miscompares++; $display("FAIL host_count: done=%b cnt=%0d expected 1 300", seen, bus.byte_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d; bit w0, clash, seen, viol; int lat, nrd, rc, cyc, bh;
        logic [ADDR_W-1:0] ra;
        logic [24:0] a;
        bit inr;
        for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);
        start_session();
        for (int i = 0; i < 60; i++) begin
            inr  = ($urandom_range(0, 3) != 0);
            a    = inr ? 25'($urandom_range(0, SIZE - 1))
                       : 25'($urandom_range(SIZE, 32'h1FF_FFFF));
            bh   = $urandom_range(0, 4);
            viol = $urandom_range(0, 1);
            host_read(a, bh, viol, d, w0, lat, nrd, rc, clash, ra);
            vectors++;
            if (d !== exp_byte(a)) begin
                miscompares++; $display("FAIL b2b_data[%0d]: addr=%h got %h expected %h", i, a, d, exp_byte(a));
            end
            vectors++;
            if (inr) begin
                if ({clash, 32'(nrd), 32'(rc), 32'(lat), ra} !==
                    {1'b0, 32'd1, 32'(exp_rd_cycle(bh)), 32'(exp_rd_cycle(bh) + 1 + MEM_LAT), a[ADDR_W-1:0]}) begin
                    miscompares++; $display("FAIL b2b_timing[%0d]: clash=%b nrd=%0d rd_at=%0d lat=%0d addr=%h busy=%0d", i, clash, nrd, rc, lat, ra, bh);
                end
            end else if ({32'(nrd), 32'(lat)} !== {32'd0, 32'd1}) begin
                miscompares++; $display("FAIL b2b_oor[%0d]: nrd=%0d lat=%0d expected 0 1", i, nrd, lat);
            end
            model_din = exp_byte(a);
            tick();
            vectors++;
            if ({bus.ioctl_wait, bus.mem_rd} !== 2'b00) begin
                miscompares++; $display("FAIL b2b_no_queue[%0d]: wait=%b mem_rd=%b expected 0 0", i, bus.ioctl_wait, bus.mem_rd);
            end
        end
        end_session(seen, cyc);
        vectors++;
        if ({seen, bus.byte_cnt} !== {1'b1, 16'd60}) begin
            miscompares++; $display("FAIL b2b_count: done=%b cnt=%0d expected 1 60", seen, bus.byte_cnt);
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus.save_trig    = 1'b0;
        bus.ioctl_upload = 1'b0;
        bus.ioctl_index  = 8'd0;
        bus.ioctl_rd     = 1'b0;
        bus.ioctl_addr   = '0;
        bus.mem_busy     = 1'b0;
        for (int i = 0; i < SIZE; i++) mem[i] = 8'($urandom);

        test_reset();
        test_happy_path();
        test_arbitration();
        test_out_of_range();
        test_timeout();
        test_index_filter();
        test_abort();
        test_reset_mid_lat();
        test_host_initiated();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/ioctl_upload_server.md
Name: ioctl_upload_server

Overview:
- Serves HPS upload (core→HPS) transfers of on-chip memory, e.g. Studio II RAM or cartridge save data.
- It is the reader counterpart to the existing ioctl download path.
- Sits between hps_io's upload interface and a single synchronous memory read port that is shared with the console core.
- Requests the upload, arbitrates for memory, stalls the HPS with ioctl_wait while fetching, and returns one byte per ioctl_rd.

Parameters:
- ADDR_W, 12, memory address width; upload byte address bits beyond ADDR_W are out of range.
- SIZE, 2048, number of valid bytes; addresses >= SIZE return PAD.
- PAD, 8'hFF, byte returned for out-of-range addresses.
- MEM_LAT, 1, cycles from mem_rd to mem_q valid (1..3).
- INDEX, 8'd1, ioctl_index value this block answers to.
- REQ_TIMEOUT, 16'hFFFF, cycles to hold ioctl_upload_req before abandoning.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- save_trig  in  1  one-cycle pulse to start a save
- ioctl_upload_req  out  1  request to HPS to begin upload
- ioctl_upload  in  1  HPS upload in progress
- ioctl_index  in  8  transfer index from hps_io
- ioctl_rd  in  1  one-cycle byte read strobe
- ioctl_addr  in  25  byte address of the read
- ioctl_din  out  8  byte returned to HPS
- ioctl_wait  out  1  stall to HPS
- mem_busy  in  1  core owns memory this cycle
- mem_rd  out  1  one-cycle read strobe
- mem_addr  out  ADDR_W  memory read address
- mem_q  in  8  memory read data
- busy  out  1  block is not IDLE
- done  out  1  one-cycle pulse at end of upload
- byte_cnt  out  16  bytes served in the current or last upload

Behaviour:
- Reset values: ioctl_upload_req=0, ioctl_din=8'h00, ioctl_wait=0, mem_rd=0, mem_addr=0, busy=0, done=0, byte_cnt=0. State goes to IDLE.
- Reset mid-transfer aborts immediately and emits no done pulse.
- "sel" means ioctl_upload && (ioctl_index==INDEX).
- IDLE:
  - save_trig → REQ, and byte_cnt clears.
  - sel rising without a prior trigger (host-initiated upload) → ACTIVE directly, and byte_cnt clears.
  - save_trig while already busy is ignored.
- REQ:
  - ioctl_upload_req=1; a timeout counter runs.
  - sel → ACTIVE; the request drops in the same cycle the transition is registered.
  - Counter reaches REQ_TIMEOUT → IDLE with no done pulse.
- ACTIVE:
  - Waits for ioctl_rd.
  - On ioctl_rd, latch ioctl_addr and raise ioctl_wait in the next cycle.
  - Out of range (ioctl_addr >= SIZE): ioctl_din<=PAD and → ACTIVE, with ioctl_wait low again 1 cycle after rd.
  - In range: → ARB.
  - sel falling → IDLE, with done=1 for one cycle.
- ARB:
  - ioctl_wait=1.
  - While mem_busy=1, hold and issue nothing.
  - First cycle with mem_busy=0: mem_rd=1 for exactly one cycle, mem_addr=latched address[ADDR_W-1:0] → LAT.
- LAT:
  - Counts MEM_LAT cycles after the mem_rd cycle, then captures mem_q into ioctl_din.
  - Drops ioctl_wait in the same cycle as the capture, increments byte_cnt → ACTIVE.
  - byte_cnt saturates at 16'hFFFF.
  - Out-of-range reads also increment byte_cnt.
- ioctl_din holds its value until the next capture.
- With mem_busy=0, the minimum in-range rd-to-data latency is 2+MEM_LAT cycles.
- ioctl_rd while ioctl_wait=1 is a protocol violation: ignore it and do not queue it.
- sel falling while in ARB or LAT: finish the pending memory read (no orphaned mem_rd), discard the data, then → IDLE with done=1.
- ioctl_rd with sel=0 (another index or no upload) is ignored in all states.
- mem_addr is held between reads.

Test Plan:
- Happy path: preload memory 0x000=0x12, 0x001=0x34, MEM_LAT=1; pulse save_trig → ioctl_upload_req=1 the next cycle; host raises ioctl_upload with index 1 → req drops; rd@0 then rd@1 → ioctl_din=0x12 then 0x34, each valid 3 cycles after rd; drop upload → done pulse, byte_cnt=2.
- Arbitration: hold mem_busy=1 for 10 cycles across rd@5 (mem[5]=0xA5) → no mem_rd while busy; ioctl_wait stays high; mem_rd issues the cycle busy falls; data 0xA5 follows MEM_LAT later.
- Out of range: rd@2048 and rd@4095 → ioctl_din=0xFF, mem_rd never asserted, ioctl_wait high for exactly 1 cycle each.
- Timeout/index filter: REQ_TIMEOUT=16, save_trig with no upload → req high 16 cycles, then IDLE and no done; upload with index 2 plus rd pulses → no response and ioctl_din unchanged.
- Abort: drop ioctl_upload while in ARB with mem_busy=1 → single mem_rd after busy clears, done pulses afterwards; assert reset mid-LAT → all outputs at reset values the next cycle.
- Host-initiated: upload index 1 without save_trig, 300 sequential reads of an incrementing pattern → every byte matches, byte_cnt=300.
